mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles a granted access waits for mem_response before error completion.
REQ-002 SHALL have ports (clk, reset synchronous active-high; reset reset, synchronous, active-high; clock clk):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_read_request  in  1  instruction-side read, level, held until i_read_response
- i_addr  in  32  instruction read address
- i_read_response  out  1  one-cycle completion pulse to instruction side
- i_read_data  out  32  instruction read data, valid with i_read_response
- d_read_request  in  1  data-side read, level, held until d_response
- d_write_request  in  1  data-side write, level, held until d_response
- d_addr  in  32  data address
- d_write_data  in  32  write data
- d_write_strobe  in  4  byte enables for write
- d_response  out  1  one-cycle completion pulse to data side
- d_read_data  out  32  data read data, valid with d_response
- mem_read_request  out  1  shared memory read, level
- mem_write_request  out  1  shared memory write, level
- mem_addr  out  32  shared memory address
- mem_write_data  out  32  shared memory write data
- mem_write_strobe  out  4  shared memory byte enables
- mem_response  in  1  memory completion pulse
- mem_read_data  in  32  memory read data, valid with mem_response
- bus_error  out  1  pulses with a requester response when access timed out

Function
REQ-003 SHALL implement states IDLE, SERVE_I, SERVE_D; one access outstanding at a time.
REQ-004 In IDLE, on a clock edge with a pending request, SHALL latch address/data/strobe/op of the winner and enter SERVE_I or SERVE_D.
REQ-005 Arbitration SHALL be round-robin: single request wins; on tie, winner is the side not granted last; last_grant register updates on every grant.
REQ-006 d_read_request and d_write_request both high SHALL be treated as a write.
REQ-007 mem_* outputs SHALL be registered, driven only from latched values, asserted from the first cycle in SERVE_x through the cycle mem_response is seen, and zero (request/strobe) in IDLE.
REQ-008 In SERVE_x, mem_response SHALL produce, combinationally in the same cycle, the matching response pulse with read data = mem_read_data (0 for writes); state returns to IDLE on that edge.
REQ-009 Minimum latency: request seen at edge n -> mem request high in cycle n+1 -> response earliest in cycle n+1 (zero-wait memory).
REQ-010 Requesters SHALL drop or change request registered on the response edge; arbiter SHALL re-arbitrate in IDLE on the next edge (one IDLE cycle between accesses).
REQ-011 Timeout counter SHALL clear on grant and increment each SERVE cycle; at count = TIMEOUT_CYCLES without mem_response, the matching response SHALL pulse with data 0 and bus_error=1, mem requests drop, state goes IDLE.
REQ-012 mem_response in IDLE SHALL be ignored (no response, no error).
REQ-013 Non-granted requester SHALL see no response and its request SHALL remain pending without loss.

Reset
REQ-014 Reset SHALL force IDLE, last_grant = D (instruction wins first tie), counter 0, all outputs 0; mem_response arriving mid-reset or in the cycle after reset SHALL be ignored.
REQ-015 Reset mid-access SHALL abandon the access with no requester response.

Structure
REQ-016 State encoding, TIMEOUT_CYCLES default and grant-side enum SHALL live in shared package core_pkg.
REQ-017 SHALL be a single module; no sub-module.

Verification
REQ-018 Both sides request in cycle 0 after reset -> I granted first, mem_addr = i_addr; after its response, D granted next.
REQ-019 D write 0x100, data 0xDEADBEEF, strobe 0xF, memory responds after 3 cycles -> mem_write_request high 3 cycles, d_response 1 cycle, bus_error 0.
REQ-020 Continuous I and D requests for 8 accesses -> grants alternate I,D,I,D..., no starvation.
REQ-021 TIMEOUT_CYCLES=4, I read, memory silent -> i_read_response + bus_error pulse at 4th SERVE cycle, i_read_data 0, then IDLE.
REQ-022 Reset asserted during SERVE_D with later mem_response -> no d_response, all outputs 0, next grant works normally.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ==========================================================================
// core_pkg -- shared arbiter state encoding, grant-side enum and defaults.
// Rev 1.0
// ==========================================================================
package core_pkg;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_side_e;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ==========================================================================
// mem_arbiter -- round-robin instruction/data arbiter onto one memory port.
// Rev 1.0
// ==========================================================================
module mem_arbiter
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_read_request,
  input  logic [31:0] i_addr,
  output logic        i_read_response,
  output logic [31:0] i_read_data,
  input  logic        d_read_request,
  input  logic        d_write_request,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_write_data,
  input  logic [3:0]  d_write_strobe,
  output logic        d_response,
  output logic [31:0] d_read_data,
  output logic        mem_read_request,
  output logic        mem_write_request,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_strobe,
  input  logic        mem_response,
  input  logic [31:0] mem_read_data,
  output logic        bus_error
);

  // Counter only ever reaches TIMEOUT_CYCLES-1 before the access ends.
  localparam int C_CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e         r_state;
  arb_state_e         w_state_next;
  grant_side_e        r_last_grant;
  logic [C_CNT_W-1:0] r_count;

  logic w_serving;
  logic w_timeout;
  logic w_done;
  logic w_i_pending;
  logic w_d_pending;
  logic w_pick_d;
  logic w_grant;

  assign w_serving   = (r_state != ST_IDLE);
  assign w_timeout   = w_serving && !mem_response && (r_count == C_CNT_LAST);
  assign w_done      = w_serving && (mem_response || w_timeout);
  assign w_i_pending = i_read_request;
  assign w_d_pending = d_read_request || d_write_request;
  assign w_pick_d    = w_d_pending && (!w_i_pending || (r_last_grant == GRANT_I));
  assign w_grant     = (r_state == ST_IDLE) && (w_i_pending || w_d_pending);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    i_read_response = 1'b0;
    i_read_data     = 32'd0;
    d_response      = 1'b0;
    d_read_data     = 32'd0;
    bus_error       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_next = w_pick_d ? ST_SERVE_D : ST_SERVE_I;
        end
      end
      ST_SERVE_I, ST_SERVE_D: begin
        if (w_done) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Responses are suppressed while reset is held so an abandoned access stays silent.
    if (!reset && w_done) begin
      bus_error = w_timeout;
      if (r_state == ST_SERVE_I) begin
        i_read_response = 1'b1;
        i_read_data     = w_timeout ? 32'd0 : mem_read_data;
      end else begin
        d_response  = 1'b1;
        d_read_data = (w_timeout || mem_write_request) ? 32'd0 : mem_read_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant      <= GRANT_D;
      r_count           <= '0;
      mem_read_request  <= 1'b0;
      mem_write_request <= 1'b0;
      mem_addr          <= 32'd0;
      mem_write_data    <= 32'd0;
      mem_write_strobe  <= 4'd0;
    end else if (w_grant) begin
      r_count      <= '0;
      r_last_grant <= w_pick_d ? GRANT_D : GRANT_I;
      if (w_pick_d) begin
        mem_addr          <= d_addr;
        mem_write_data    <= d_write_data;
        mem_write_strobe  <= d_write_request ? d_write_strobe : 4'd0;
        mem_write_request <= d_write_request;
        mem_read_request  <= !d_write_request;
      end else begin
        mem_addr          <= i_addr;
        mem_write_data    <= 32'd0;
        mem_write_strobe  <= 4'd0;
        mem_write_request <= 1'b0;
        mem_read_request  <= 1'b1;
      end
    end else if (w_done) begin
      mem_read_request  <= 1'b0;
      mem_write_request <= 1'b0;
      mem_write_strobe  <= 4'd0;
    end else if (w_serving) begin
      r_count <= r_count + C_CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_mem_arbiter -- random requesters and memory against a transaction-level model.
// Rev 1.0
// ==========================================================================
module tb_mem_arbiter;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_read_request;
  logic [31:0] i_addr;
  logic        i_read_response;
  logic [31:0] i_read_data;
  logic        d_read_request;
  logic        d_write_request;
  logic [31:0] d_addr;
  logic [31:0] d_write_data;
  logic [3:0]  d_write_strobe;
  logic        d_response;
  logic [31:0] d_read_data;
  logic        mem_read_request;
  logic        mem_write_request;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_strobe;
  logic        mem_response;
  logic [31:0] mem_read_data;
  logic        bus_error;

  mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .i_read_request(i_read_request), .i_addr(i_addr),
    .i_read_response(i_read_response), .i_read_data(i_read_data),
    .d_read_request(d_read_request), .d_write_request(d_write_request),
    .d_addr(d_addr), .d_write_data(d_write_data), .d_write_strobe(d_write_strobe),
    .d_response(d_response), .d_read_data(d_read_data),
    .mem_read_request(mem_read_request), .mem_write_request(mem_write_request),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_write_strobe(mem_write_strobe),
    .mem_response(mem_response), .mem_read_data(mem_read_data),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          side_d;
    logic [31:0] data;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          model_last_d = 1'b1;
  bit          m_active = 1'b0;
  int          m_wait;
  int          m_delay;
  logic [31:0] m_rdata;
  bit          i_done = 1'b0;
  bit          d_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every requester response must match the oldest expectation.
  always @(negedge clk) begin
    if (i_read_response || d_response) begin
      check32("single_response", 32'(i_read_response & d_response), 32'd0);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_response: got i=%0b d=%0b expected none (cycle %0d)",
                 i_read_response, d_response, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check32("resp_side", 32'(d_response), 32'(e.side_d));
        check32("resp_data", d_response ? d_read_data : i_read_data, e.data);
        check32("resp_bus_error", 32'(bus_error), 32'(e.err));
        check32("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else begin
      check32("bus_error_without_response", 32'(bus_error), 32'd0);
    end
  end

  // One clock of random requesters plus a random-latency memory.
  task automatic step(bit issue_en);
    bit          s_i, s_dr, s_dw, s_d, win_d, exp_w, err;
    logic [31:0] s_ia, s_da, s_dwd;
    logic [3:0]  s_ds;
    int          op;
    @(posedge clk); #1;
    s_i = i_read_request; s_dr = d_read_request; s_dw = d_write_request;
    s_ia = i_addr; s_da = d_addr; s_dwd = d_write_data; s_ds = d_write_strobe;
    s_d = s_dr | s_dw;

    if (!i_read_request || i_done) begin
      if (issue_en && $urandom_range(0, 3) != 0) begin
        i_read_request = 1'b1;
        i_addr = $urandom;
      end else begin
        i_read_request = 1'b0;
      end
    end
    if (!(d_read_request || d_write_request) || d_done) begin
      if (issue_en && $urandom_range(0, 3) != 0) begin
        op = $urandom_range(0, 2);
        d_read_request  = (op != 1);
        d_write_request = (op != 0);
        d_addr = $urandom; d_write_data = $urandom; d_write_strobe = 4'($urandom);
      end else begin
        d_read_request = 1'b0; d_write_request = 1'b0;
      end
    end

    #1;
    if (mem_read_request || mem_write_request) begin
      if (!m_active) begin
        m_active = 1'b1; m_wait = 0;
        m_delay = $urandom_range(0, 10); m_rdata = $urandom;
        if (s_i && s_d) win_d = !model_last_d;
        else if (s_d) win_d = 1'b1;
        else begin
          win_d = 1'b0;
          check32("grant_with_request_pending", 32'(s_i), 32'd1);
        end
        model_last_d = win_d;
        exp_w = win_d && s_dw;
        check32("grant_addr", mem_addr, win_d ? s_da : s_ia);
        check32("grant_write_op", 32'(mem_write_request), 32'(exp_w));
        check32("grant_read_op", 32'(mem_read_request), 32'(!exp_w));
        if (exp_w) begin
          check32("grant_wdata", mem_write_data, s_dwd);
          check32("grant_strobe", 32'(mem_write_strobe), 32'(s_ds));
        end
        err = (m_delay >= T);
        sb_q.push_back('{side_d: win_d, data: (err || exp_w) ? 32'd0 : m_rdata,
                         err: err, cyc: cyc + (err ? T - 1 : m_delay)});
      end else begin
        m_wait++;
      end
      mem_response  = (m_wait == m_delay);
      mem_read_data = mem_response ? m_rdata : $urandom;
    end else begin
      m_active = 1'b0;
      mem_response  = ($urandom_range(0, 5) == 0);
      mem_read_data = $urandom;
    end

    @(negedge clk);
    i_done = i_read_response;
    d_done = d_response;
  endtask

  task automatic drain();
    int k = 0;
    while ((i_read_request || d_read_request || d_write_request || m_active ||
            sb_q.size() != 0) && k < 300) begin
      step(1'b0);
      k++;
    end
    check32("drain_requests_idle", 32'(i_read_request | d_read_request | d_write_request), 32'd0);
    check32("drain_scoreboard_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic directed_write();
    int hi = 0;
    @(posedge clk); #1;
    mem_response = 1'b0;
    d_read_request = 1'b0; d_write_request = 1'b1;
    d_addr = 32'h100; d_write_data = 32'hDEAD_BEEF; d_write_strobe = 4'hF;
    sb_q.push_back('{side_d: 1'b1, data: 32'd0, err: 1'b0, cyc: cyc + 3});
    model_last_d = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 4) d_write_request = 1'b0;
      #1;
      mem_response  = (k == 3);
      mem_read_data = 32'h1234_5678;
      @(negedge clk);
      if (k == 1) begin
        check32("dw_addr", mem_addr, 32'h100);
        check32("dw_wdata", mem_write_data, 32'hDEAD_BEEF);
        check32("dw_strobe", 32'(mem_write_strobe), 32'hF);
      end
      if (mem_write_request) hi++;
    end
    mem_response = 1'b0;
    check32("dw_write_request_cycles", 32'(hi), 32'd3);
  endtask

  task automatic reset_mid_access();
    @(posedge clk); #1;
    d_read_request = 1'b1; d_addr = 32'h200;
    @(posedge clk); #1;
    @(negedge clk);
    check32("rst_access_started", 32'(mem_read_request), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1 mem_response = 1'b1; mem_read_data = 32'hCAFE_F00D;
    @(negedge clk);
    check32("rst_no_d_response", 32'(d_response), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; d_read_request = 1'b0;
    @(negedge clk);
    check32("rst_after_mem_req", 32'({mem_read_request, mem_write_request}), 32'd0);
    check32("rst_after_mem_addr", mem_addr, 32'd0);
    check32("rst_after_strobe", 32'(mem_write_strobe), 32'd0);
    check32("rst_after_resp", 32'({i_read_response, d_response, bus_error}), 32'd0);
    @(posedge clk); #1;
    mem_response = 1'b0;
    model_last_d = 1'b1; m_active = 1'b0; i_done = 1'b0; d_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    i_read_request = 1'b0; i_addr = 32'd0;
    d_read_request = 1'b0; d_write_request = 1'b0;
    d_addr = 32'd0; d_write_data = 32'd0; d_write_strobe = 4'd0;
    mem_response = 1'b0; mem_read_data = 32'd0;

    repeat (2) @(posedge clk);
    #1 mem_response = 1'b1; mem_read_data = 32'hA5A5_A5A5;
    @(negedge clk);
    check32("reset_mem_req", 32'({mem_read_request, mem_write_request}), 32'd0);
    check32("reset_mem_addr", mem_addr, 32'd0);
    check32("reset_mem_wdata", mem_write_data, 32'd0);
    check32("reset_responses", 32'({i_read_response, d_response, bus_error}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    i_read_request = 1'b1; i_addr = $urandom;
    d_read_request = 1'b1; d_addr = $urandom;
    @(negedge clk);
    check32("post_reset_mem_response_ignored",
            32'({i_read_response, d_response, bus_error, mem_read_request}), 32'd0);

    for (int c = 0; c < 600; c++) step(1'b1);
    drain();
    directed_write();
    reset_mid_access();
    i_read_request = 1'b1; i_addr = $urandom;
    d_read_request = 1'b1; d_addr = $urandom;
    for (int c = 0; c < 300; c++) step(1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected $finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
